nonce_work_scheduler: RTL and testbench
=======================================

NONCE_WORK_SCHEDULER -- requirements
Module: nonce_work_scheduler

Interface
REQ-001 The block SHALL take parameter PIPE_LAT, default 130, meaning cycles from a nonce being issued to the core until its core_gold result is presented.
REQ-002 The block SHALL take parameter NONCE_STEP, default 1, meaning nonce increment per issue cycle; legal values are 1, 2 and 4.
REQ-003 The block SHALL take parameter FIFO_DEPTH, default 4, meaning number of result FIFO entries; it is a power of two.
REQ-004 Port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 Port rst_n  input  1  reset; asynchronous assert, active-low.
REQ-006 Ports work_valid in 1, work_ready out 1  new-work handshake; transfer when both are high on a clock edge.
REQ-007 Ports work_midstate in 256, work_data in 96, work_nonce_start in 32  work payload, sampled on transfer.
REQ-008 Port work_abort  input  1  one-cycle request to stop the current work.
REQ-009 Ports core_midstate out 256, core_data out 96, core_nonce out 32  hasher inputs.
REQ-010 Port core_issue  output  1  core_nonce is a real issue this cycle.
REQ-011 Port core_gold  input  1  hash of the nonce issued PIPE_LAT cycles earlier meets target.
REQ-012 Ports result_valid out 1, result_ready in 1, result_nonce out 32  golden-nonce output handshake toward the serial transmitter.
REQ-013 Ports busy out 1 (state is not IDLE) and overflow out 1 (sticky result drop).

Function
REQ-014 The block SHALL implement states IDLE, RUN and DRAIN.
REQ-015 In IDLE, work_ready SHALL be 1; in RUN and DRAIN it SHALL be 0.
REQ-016 On work transfer, payload SHALL be registered, core_nonce SHALL be loaded with work_nonce_start, and the state SHALL become RUN on the next cycle.
REQ-017 In RUN, core_issue SHALL be 1 and core_nonce SHALL advance by NONCE_STEP each cycle, modulo 2^32.
REQ-018 In IDLE and DRAIN, core_issue SHALL be 0 while core_nonce keeps advancing by NONCE_STEP.
REQ-019 RUN SHALL go to DRAIN after exactly 2^32/NONCE_STEP issues, so that the next nonce would equal work_nonce_start.
REQ-020 RUN SHALL go to DRAIN in the cycle after work_abort is sampled high; work_abort in IDLE or DRAIN SHALL be ignored.
REQ-021 DRAIN SHALL last exactly PIPE_LAT cycles, then go to IDLE.
REQ-022 The block SHALL delay core_issue by PIPE_LAT cycles.
REQ-023 A core_gold pulse SHALL be accepted only when the delayed issue bit is 1, and is ignored otherwise.
REQ-024 For an accepted core_gold, the golden nonce SHALL be core_nonce − PIPE_LAT×NONCE_STEP, modulo 2^32 (wrap-around allowed).
REQ-025 Accepted golden nonces SHALL be pushed into a FIFO_DEPTH-entry FIFO whose head drives result_nonce, with result_valid equal to FIFO not empty.
REQ-026 When the FIFO is full, a pushed nonce SHALL be dropped and overflow set, unless a pop occurs in the same cycle, in which case both the pop and the push succeed.
REQ-027 A simultaneous push and pop on an empty FIFO SHALL push only; result_valid rises the next cycle.
REQ-028 core_midstate and core_data SHALL hold the registered payload until the next work transfer.

Reset
REQ-029 While rst_n is 0, the state SHALL be IDLE, core_issue 0, core_nonce 0, core_midstate 0, core_data 0, FIFO empty, result_valid 0, overflow 0, and the delay line all zeros.
REQ-030 A reset mid-RUN or mid-DRAIN SHALL discard in-flight work and queued results, with no output pulse after deassert.
REQ-031 The first work transfer SHALL be possible on the first rising edge after rst_n deasserts.

Verification
REQ-032 Load midstate 256'h635e...437b, data 96'he5e1081ae9a4374e1e8d8d13, start 32'h195a2c52; pulse core_gold 131 cycles after transfer -> result_nonce=32'h195a2c52, result_valid=1.
REQ-033 Start 32'hFFFFFFFE, gold on the third issue -> result_nonce=32'h00000000, which is modular wrap.
REQ-034 Abort 10 cycles into RUN -> core_issue=0 the next cycle, golden nonces of the first 10 issues still reported, later core_gold ignored, IDLE after 130 DRAIN cycles.
REQ-035 Six golds with result_ready=0 -> four results held in order, overflow=1; result_ready=1 -> four results drain, result_valid falls.
REQ-036 Assert rst_n=0 mid-RUN with two results queued -> all outputs take reset values immediately, work_ready=1 after release.

Source files
------------

// File: rtl/nonce_work_scheduler.sv
// ---------------------------------------------------------------------------
// nonce_work_scheduler
//   Feeds one unit of hashing work to a pipelined double-SHA core. It walks
//   the nonce space from work_nonce_start and tracks which core_gold pulses
//   belong to real issues. Golden nonces are queued in a small result FIFO
//   for the serial transmitter.
//
// Parameters
//   PIPE_LAT    cycles from a nonce issue to its core_gold result
//   NONCE_STEP  nonce increment per cycle (1, 2 or 4)
//   FIFO_DEPTH  result FIFO entries (power of two)
//
// Ports
//   clk, rst_n                       clock, async active-low reset
//   work_valid/work_ready            new-work handshake (ready only in IDLE)
//   work_midstate/data/nonce_start   work payload, captured on transfer
//   work_abort                       one-cycle stop request, honoured in RUN
//   core_midstate/data/nonce         hasher inputs
//   core_issue                       core_nonce is a real issue this cycle
//   core_gold                        hash of nonce issued PIPE_LAT ago hits
//   result_valid/ready/nonce         golden-nonce FIFO head handshake
//   busy                             state is not IDLE
//   overflow                         sticky: a golden nonce was dropped
// ---------------------------------------------------------------------------
module nonce_work_scheduler #(
    parameter int PIPE_LAT   = 130,
    parameter int NONCE_STEP = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         work_valid,
    output logic         work_ready,
    input  logic [255:0] work_midstate,
    input  logic [95:0]  work_data,
    input  logic [31:0]  work_nonce_start,
    input  logic         work_abort,
    output logic [255:0] core_midstate,
    output logic [95:0]  core_data,
    output logic [31:0]  core_nonce,
    output logic         core_issue,
    input  logic         core_gold,
    output logic         result_valid,
    input  logic         result_ready,
    output logic [31:0]  result_nonce,
    output logic         busy,
    output logic         overflow
);

    localparam logic [31:0] STEP32  = 32'(NONCE_STEP);
    // distance between the nonce on the bus and the one that produced core_gold
    localparam logic [31:0] BACKOFF = 32'(PIPE_LAT * NONCE_STEP);

    localparam int DCNT_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
    localparam logic [DCNT_W-1:0] DRAIN_LAST = DCNT_W'(PIPE_LAT - 1);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [255:0]        midstate_q;
    logic [95:0]         data_q;
    logic [31:0]         nonce_q, nonce_d;
    logic [31:0]         start_q;
    logic [DCNT_W-1:0]   drain_cnt_q, drain_cnt_d;
    logic                load;
    logic [31:0]         nonce_nxt;

    // vld_pipe_q[k] is core_issue from k cycles ago
    logic [PIPE_LAT:1]   vld_pipe_q;

    logic [31:0]         fifo_q [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                ovf_q;
    logic                push_req, push, pop, full, drop;
    logic [31:0]         golden;

    assign nonce_nxt = nonce_q + STEP32;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        nonce_d     = nonce_nxt;     // nonce free-runs in every state
        drain_cnt_d = drain_cnt_q;
        load        = 1'b0;
        work_ready  = 1'b0;
        core_issue  = 1'b0;
        busy        = 1'b1;
        case (state_q)
            S_IDLE: begin
                work_ready = 1'b1;
                busy       = 1'b0;
                if (work_valid) begin
                    load    = 1'b1;
                    nonce_d = work_nonce_start;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                core_issue = 1'b1;
                // the space is exhausted once the next nonce would repeat the start
                if (work_abort || (nonce_nxt == start_q)) begin
                    state_d     = S_DRAIN;
                    drain_cnt_d = '0;
                end
            end
            S_DRAIN: begin
                if (drain_cnt_q == DRAIN_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    drain_cnt_d = drain_cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            nonce_q     <= '0;
            start_q     <= '0;
            midstate_q  <= '0;
            data_q      <= '0;
            drain_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            nonce_q     <= nonce_d;
            drain_cnt_q <= drain_cnt_d;
            if (load) begin
                start_q    <= work_nonce_start;
                midstate_q <= work_midstate;
                data_q     <= work_data;
            end
        end
    end

    assign core_midstate = midstate_q;
    assign core_data     = data_q;
    assign core_nonce    = nonce_q;

    // ------------------------------------------------------------------
    // Issue delay line, aligned with the core pipeline
    // ------------------------------------------------------------------
    generate
        if (PIPE_LAT == 1) begin : g_pipe1
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) vld_pipe_q <= '0;
                else        vld_pipe_q <= core_issue;
            end
        end else begin : g_pipen
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) vld_pipe_q <= '0;
                else        vld_pipe_q <= {vld_pipe_q[PIPE_LAT-1:1], core_issue};
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Golden-nonce FIFO
    // ------------------------------------------------------------------
    assign golden       = nonce_q - BACKOFF;
    assign push_req     = core_gold & vld_pipe_q[PIPE_LAT];
    assign result_valid = (count_q != '0);
    assign pop          = result_valid & result_ready;
    assign full         = (count_q == FULL_CNT);
    // a pop in the same cycle frees the slot the push needs
    assign push         = push_req & (~full | pop);
    assign drop         = push_req & full & ~pop;
    assign result_nonce = fifo_q[rd_ptr_q];
    assign overflow     = ovf_q;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            if (push) begin
                fifo_q[wr_ptr_q] <= golden;
                wr_ptr_q <= (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
            end
            if (drop) ovf_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_nonce_work_scheduler.sv
`timescale 1ns/1ps
module tb_nonce_work_scheduler;
    localparam int L     = 130;
    localparam int STEP  = 1;
    localparam int DEPTH = 4;
    localparam longint NO_ABORT = 64'h0000_7fff_ffff_ffff;
    localparam logic [255:0] MID = 256'h635e9c1a7f3b2d48e0a5c6b7d1f2e3a4b5c6d7e8f9a0b1c2d3e4f5a6b7c8437b;
    localparam logic [95:0]  DAT = 96'he5e1081ae9a4374e1e8d8d13;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         work_valid = 1'b0, work_ready;
    logic [255:0] work_midstate = '0;
    logic [95:0]  work_data = '0;
    logic [31:0]  work_nonce_start = '0;
    logic         work_abort = 1'b0;
    logic [255:0] core_midstate;
    logic [95:0]  core_data;
    logic [31:0]  core_nonce;
    logic         core_issue;
    logic         core_gold = 1'b0;
    logic         result_valid;
    logic         result_ready = 1'b0;
    logic [31:0]  result_nonce;
    logic         busy, overflow;

    always #5 clk = ~clk;

    nonce_work_scheduler #(.PIPE_LAT(L), .NONCE_STEP(STEP), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .work_valid(work_valid), .work_ready(work_ready),
        .work_midstate(work_midstate), .work_data(work_data), .work_nonce_start(work_nonce_start),
        .work_abort(work_abort),
        .core_midstate(core_midstate), .core_data(core_data), .core_nonce(core_nonce),
        .core_issue(core_issue), .core_gold(core_gold),
        .result_valid(result_valid), .result_ready(result_ready), .result_nonce(result_nonce),
        .busy(busy), .overflow(overflow)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model: slot = cycles since the transfer edge; issue i happens in
    // slot i with nonce start+i*STEP; a gold seen in slot s refers to issue s-L.
    bit          m_active = 1'b0;
    longint      m_slot = 0;
    longint      m_last_issue = -1;
    logic [31:0] m_start = '0;
    logic [31:0] mq[$];
    bit          m_ovf = 1'b0;

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // apply the current inputs to the model, then advance one clock
    task automatic adv();
        longint g;
        if (m_active && work_abort && m_slot <= m_last_issue) m_last_issue = m_slot;
        g = m_slot - L;
        if (mq.size() > 0 && result_ready) void'(mq.pop_front());
        if (m_active && core_gold && g >= 0 && g <= m_last_issue) begin
            if (mq.size() < DEPTH) mq.push_back(m_start + 32'(g * STEP));
            else m_ovf = 1'b1;
        end
        m_slot++;
        tick();
    endtask

    task automatic run_to(input longint s);
        while (m_slot < s) adv();
    endtask

    task automatic start_work(input logic [255:0] mid, input logic [95:0] dat, input logic [31:0] st);
        work_midstate = mid; work_data = dat; work_nonce_start = st; work_valid = 1'b1;
        adv();
        work_valid = 1'b0;
        m_active = 1'b1; m_start = st; m_slot = 0; m_last_issue = NO_ABORT;
    endtask

    task automatic finish_work();
        work_abort = 1'b1;
        adv();
        work_abort = 1'b0;
        repeat (L + 1) adv();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++; if (work_ready !== 1'b1) begin miscompares++; $display("FAIL rst_work_ready got=%0b exp=1", work_ready); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy got=%0b exp=0", busy); end
        vectors++; if (core_issue !== 1'b0) begin miscompares++; $display("FAIL rst_core_issue got=%0b exp=0", core_issue); end
        vectors++; if (core_nonce !== 32'h0) begin miscompares++; $display("FAIL rst_core_nonce got=%h exp=0", core_nonce); end
        vectors++; if (core_midstate !== 256'h0) begin miscompares++; $display("FAIL rst_core_midstate got=%h exp=0", core_midstate); end
        vectors++; if (core_data !== 96'h0) begin miscompares++; $display("FAIL rst_core_data got=%h exp=0", core_data); end
        vectors++; if (result_valid !== 1'b0) begin miscompares++; $display("FAIL rst_result_valid got=%0b exp=0", result_valid); end
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL rst_overflow got=%0b exp=0", overflow); end
        rst_n = 1'b1;
        m_active = 1'b0; m_start = '0; m_slot = 0; mq.delete(); m_ovf = 1'b0;
        adv();
        vectors++; if (core_nonce !== 32'(STEP)) begin miscompares++; $display("FAIL idle_nonce_adv got=%h exp=%h", core_nonce, 32'(STEP)); end
        vectors++; if (core_issue !== 1'b0) begin miscompares++; $display("FAIL idle_issue got=%0b exp=0", core_issue); end
    endtask

    task automatic test_basic();
        logic [31:0] st = 32'h195a2c52;
        result_ready = 1'b0;
        vectors++; if (work_ready !== 1'b1) begin miscompares++; $display("FAIL basic_ready got=%0b exp=1", work_ready); end
        start_work(MID, DAT, st);
        vectors++; if (core_issue !== 1'b1) begin miscompares++; $display("FAIL basic_issue got=%0b exp=1", core_issue); end
        vectors++; if (core_nonce !== st) begin miscompares++; $display("FAIL basic_first_nonce got=%h exp=%h", core_nonce, st); end
        vectors++; if (core_midstate !== MID) begin miscompares++; $display("FAIL basic_midstate got=%h exp=%h", core_midstate, MID); end
        vectors++; if (core_data !== DAT) begin miscompares++; $display("FAIL basic_data got=%h exp=%h", core_data, DAT); end
        vectors++; if (work_ready !== 1'b0) begin miscompares++; $display("FAIL basic_ready_run got=%0b exp=0", work_ready); end
        run_to(5);
        vectors++; if (core_nonce !== st + 32'(5 * STEP)) begin miscompares++; $display("FAIL basic_nonce5 got=%h exp=%h", core_nonce, st + 32'(5 * STEP)); end
        // gold one slot too early lines up with no issue and must be ignored
        run_to(L - 1);
        core_gold = 1'b1;
        adv();
        vectors++; if (result_valid !== 1'b0) begin miscompares++; $display("FAIL basic_early_gold got=%0b exp=0", result_valid); end
        adv();
        core_gold = 1'b0;
        vectors++; if (result_valid !== 1'b1) begin miscompares++; $display("FAIL basic_valid got=%0b exp=1", result_valid); end
        vectors++; if (result_nonce !== st) begin miscompares++; $display("FAIL basic_result got=%h exp=%h", result_nonce, st); end
        result_ready = 1'b1;
        adv();
        result_ready = 1'b0;
        vectors++; if (result_valid !== 1'b0) begin miscompares++; $display("FAIL basic_pop got=%0b exp=0", result_valid); end
        finish_work();
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL basic_idle got=%0b exp=0", busy); end
        vectors++; if (core_midstate !== MID) begin miscompares++; $display("FAIL basic_mid_hold got=%h exp=%h", core_midstate, MID); end
    endtask

    task automatic test_wrap();
        start_work(MID, DAT, 32'hFFFF_FFFE);
        run_to(2);
        vectors++; if (core_nonce !== 32'h0) begin miscompares++; $display("FAIL wrap_bus_nonce got=%h exp=0", core_nonce); end
        run_to(L + 2);
        core_gold = 1'b1;
        adv();
        core_gold = 1'b0;
        vectors++; if (result_valid !== 1'b1) begin miscompares++; $display("FAIL wrap_valid got=%0b exp=1", result_valid); end
        vectors++; if (result_nonce !== 32'h0) begin miscompares++; $display("FAIL wrap_result got=%h exp=0", result_nonce); end
        result_ready = 1'b1;
        adv();
        result_ready = 1'b0;
        finish_work();
    endtask

    task automatic test_abort();
        logic [31:0] st = $urandom;
        result_ready = 1'b0;
        start_work(MID, DAT, st);
        run_to(9);
        work_abort = 1'b1;
        adv();
        work_abort = 1'b0;
        vectors++; if (core_issue !== 1'b0) begin miscompares++; $display("FAIL abort_issue got=%0b exp=0", core_issue); end
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL abort_busy got=%0b exp=1", busy); end
        run_to(20);
        work_abort = 1'b1;   // ignored while draining
        adv();
        work_abort = 1'b0;
        run_to(L);
        core_gold = 1'b1;
        adv();
        core_gold = 1'b0;
        run_to(L + 9);
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL abort_last_drain got=%0b exp=1", busy); end
        core_gold = 1'b1;
        adv();
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL abort_idle got=%0b exp=0", busy); end
        vectors++; if (work_ready !== 1'b1) begin miscompares++; $display("FAIL abort_ready got=%0b exp=1", work_ready); end
        adv();
        core_gold = 1'b0;
        vectors++; if (result_nonce !== st) begin miscompares++; $display("FAIL abort_res0 got=%h exp=%h", result_nonce, st); end
        result_ready = 1'b1;
        adv();
        vectors++; if (result_nonce !== st + 32'(9 * STEP)) begin miscompares++; $display("FAIL abort_res9 got=%h exp=%h", result_nonce, st + 32'(9 * STEP)); end
        adv();
        vectors++; if (result_valid !== 1'b0) begin miscompares++; $display("FAIL abort_late_gold got=%0b exp=0", result_valid); end
        result_ready = 1'b0;
    endtask

    task automatic test_overflow();
        logic [31:0] st = $urandom;
        result_ready = 1'b0;
        start_work(MID, DAT, st);
        run_to(L);
        core_gold = 1'b1;
        repeat (6) adv();
        core_gold = 1'b0;
        vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_flag got=%0b exp=1", overflow); end
        vectors++; if (result_nonce !== st) begin miscompares++; $display("FAIL ovf_head0 got=%h exp=%h", result_nonce, st); end
        result_ready = 1'b1;
        for (int k = 1; k < DEPTH; k++) begin
            adv();
            vectors++; if (result_nonce !== st + 32'(k * STEP)) begin miscompares++; $display("FAIL ovf_head%0d got=%h exp=%h", k, result_nonce, st + 32'(k * STEP)); end
        end
        adv();
        vectors++; if (result_valid !== 1'b0) begin miscompares++; $display("FAIL ovf_drained got=%0b exp=0", result_valid); end
        result_ready = 1'b0;
        finish_work();
        vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_sticky got=%0b exp=1", overflow); end
    endtask

    task automatic test_reset_mid_run();
        logic [31:0] st = $urandom;
        result_ready = 1'b0;
        start_work(MID, DAT, $urandom);
        run_to(L);
        core_gold = 1'b1;
        repeat (2) adv();
        core_gold = 1'b0;
        vectors++; if (result_valid !== 1'b1) begin miscompares++; $display("FAIL rmid_queued got=%0b exp=1", result_valid); end
        rst_n = 1'b0;
        #1;
        vectors++; if (result_valid !== 1'b0) begin miscompares++; $display("FAIL rmid_valid got=%0b exp=0", result_valid); end
        vectors++; if (core_issue !== 1'b0) begin miscompares++; $display("FAIL rmid_issue got=%0b exp=0", core_issue); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rmid_busy got=%0b exp=0", busy); end
        vectors++; if (core_nonce !== 32'h0) begin miscompares++; $display("FAIL rmid_nonce got=%h exp=0", core_nonce); end
        vectors++; if (core_midstate !== 256'h0) begin miscompares++; $display("FAIL rmid_mid got=%h exp=0", core_midstate); end
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL rmid_ovf got=%0b exp=0", overflow); end
        m_active = 1'b0; mq.delete(); m_ovf = 1'b0;
        tick();
        rst_n = 1'b1;
        m_start = '0; m_slot = 0;
        vectors++; if (work_ready !== 1'b1) begin miscompares++; $display("FAIL rmid_ready got=%0b exp=1", work_ready); end
        start_work(MID, DAT, st);   // transfer on the first edge after release
        vectors++; if (core_issue !== 1'b1) begin miscompares++; $display("FAIL rmid_first_xfer got=%0b exp=1", core_issue); end
        vectors++; if (core_nonce !== st) begin miscompares++; $display("FAIL rmid_first_nonce got=%h exp=%h", core_nonce, st); end
        // stale in-flight golds from before reset must not reappear
        core_gold = 1'b1;
        for (int s = 0; s < L; s++) begin
            vectors++; if (result_valid !== 1'b0) begin miscompares++; $display("FAIL rmid_stale slot=%0d got=%0b exp=0", s, result_valid); end
            adv();
        end
        core_gold = 1'b0;
        result_ready = 1'b1;
        repeat (DEPTH + 1) adv();
        result_ready = 1'b0;
        finish_work();
    endtask

    task automatic test_random();
        logic [255:0] mid;
        logic [95:0]  dat;
        longint       a;
        logic [31:0]  en;
        for (int it = 0; it < 6; it++) begin
            for (int i = 0; i < 8; i++) mid[i*32 +: 32] = $urandom;
            for (int i = 0; i < 3; i++) dat[i*32 +: 32] = $urandom;
            a = longint'($urandom_range(40, 2));
            start_work(mid, dat, $urandom);
            for (longint s = 0; s < a + L + 6; s++) begin
                en = m_start + 32'(m_slot * STEP);
                vectors++; if (core_issue !== (m_active && m_slot <= m_last_issue)) begin miscompares++; $display("FAIL rnd_issue it=%0d slot=%0d got=%0b", it, m_slot, core_issue); end
                vectors++; if (busy !== (m_active && m_slot <= m_last_issue + L)) begin miscompares++; $display("FAIL rnd_busy it=%0d slot=%0d got=%0b", it, m_slot, busy); end
                vectors++; if (core_nonce !== en) begin miscompares++; $display("FAIL rnd_nonce it=%0d slot=%0d got=%h exp=%h", it, m_slot, core_nonce, en); end
                vectors++; if (result_valid !== (mq.size() > 0)) begin miscompares++; $display("FAIL rnd_valid it=%0d slot=%0d got=%0b exp=%0b", it, m_slot, result_valid, mq.size() > 0); end
                if (mq.size() > 0) begin
                    vectors++; if (result_nonce !== mq[0]) begin miscompares++; $display("FAIL rnd_result it=%0d slot=%0d got=%h exp=%h", it, m_slot, result_nonce, mq[0]); end
                end
                vectors++; if (overflow !== m_ovf) begin miscompares++; $display("FAIL rnd_ovf it=%0d slot=%0d got=%0b exp=%0b", it, m_slot, overflow, m_ovf); end
                vectors++; if (core_data !== dat) begin miscompares++; $display("FAIL rnd_data it=%0d got=%h exp=%h", it, core_data, dat); end
                core_gold    = ($urandom_range(2, 0) == 0);
                result_ready = ($urandom_range(1, 0) == 1);
                work_abort   = (m_slot == a) || (m_slot > a && $urandom_range(7, 0) == 0);
                adv();
            end
            core_gold = 1'b0; work_abort = 1'b0; result_ready = 1'b0;
            vectors++; if (work_ready !== 1'b1) begin miscompares++; $display("FAIL rnd_ready it=%0d got=%0b exp=1", it, work_ready); end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_abort();
        test_overflow();
        test_reset_mid_run();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
